bp_mem_responder: RTL and testbench
===================================

Name: bp_mem_responder

Overview:
- Target-side endpoint of the CCE memory-message protocol: accepts bp_cce_mem_msg_s commands and returns one response per command.
- Backed by a local block-wide SRAM model.
- Sits behind the softcore's mem_cmd/mem_resp ports as its main-memory end, or behind the io port as a scratchpad.
- Serial, one command in flight: ready/valid on commands, valid/yumi on responses.

Parameters:
- bp_params_p, e_bp_inv_cfg, aviary config; supplies paddr_width_p, cce_block_width_p and the message widths.
- els_p, 1024, number of cce_block_width_p-bit SRAM entries; must be a power of two.
- latency_p, 0, extra idle cycles between SRAM access and response valid (0..255).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- mem_cmd_i  in  cce_mem_msg_width_lp  command message.
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_o  out  1  command accepted when v&ready.
- mem_resp_o  out  cce_mem_msg_width_lp  response message.
- mem_resp_v_o  out  1  response valid.
- mem_resp_yumi_i  in  1  consumer takes response; legal only while mem_resp_v_o=1.

Behaviour:
- Reset (reset_n_i low, asynchronous): FSM=e_ready, latency counter=0, mem_resp_v_o=0, mem_resp_o=0.
  - mem_cmd_ready_o is 0 while reset is asserted and 1 in the first cycle after release.
  - SRAM contents are not reset.
- FSM e_ready: mem_cmd_ready_o=1.
  - On mem_cmd_v_i: register the full command (header + data), go to e_access.
- FSM e_access (1 cycle): SRAM access at index = addr[lg(block bytes)+:lg(els_p)].
  - Byte offset = addr[0+:lg(block bytes)], aligned down to 2^size.
  - If latency_p=0 go to e_resp, else go to e_wait.
- FSM e_wait: counter counts 0..latency_p-1, then go to e_resp.
- FSM e_resp: mem_resp_v_o=1 and mem_resp_o held stable.
  - On mem_resp_yumi_i go to e_ready.
  - mem_cmd_ready_o=0 in e_access, e_wait and e_resp.
- Minimum latency is cmd-accept edge to resp_v = 2 cycles (accept, access); adds latency_p.
  - Back-to-back throughput is one command per 3+latency_p cycles.
- Response header is the command header copied verbatim (msg_type, addr, size, payload incl. lce_id).
- Read commands (e_cce_mem_rd, e_cce_mem_uc_rd): 2^size bytes from the offset are placed in response data bits [0 +: 8*2^size]; upper bits are 0.
- Write commands (e_cce_mem_wr, e_cce_mem_uc_wr): bytes [0 +: 2^size] of command data are written at the offset with a byte mask; other bytes are unchanged.
  - Response data is 0.
  - The write is visible to the next command's read.
- Any other msg_type: no SRAM change, response data 0, normal handshake.
- Address bits above the index wrap modulo els_p.
- size greater than the block size is clamped to the full block.
- yumi is ignored while mem_resp_v_o=0.
- Reset during e_wait or e_resp drops the pending response; a write already performed in e_access stays committed.

Optional Feature:
- Macro BP_MEM_RESPONDER_RANGE_CHECK_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - A command with addr >= els_p*block bytes is out of range: it is not written, returns data 0, and sets err_o sticky until reset.
  - Handshake and latency are unchanged.
- Undefined: no err_o port; out-of-range addresses wrap as above.

Decomposition:
- bp_common_pkg supplies the existing message enums (bp_cce_mem_cmd_type_e, bp_mem_msg_size_e) and the struct macros.
- New localparam constant in bp_me_pkg: block-byte count log2 derived from cce_block_width_p.
- FSM state enum (e_ready/e_access/e_wait/e_resp) is local to the module.
- One natural sub-module: bsg_mem_1rw_sync_mask_write_byte for the SRAM; the FSM and byte steering stay in bp_mem_responder.

Test Plan:
- Reset release: hold reset_n_i low 5 cycles, then raise it → resp_v=0 throughout; ready=1 on the first cycle after release.
- Write then read:
  - uc_wr addr=0x8000_0008, size=8B, data=0xDEADBEEF_CAFEF00D → response data=0, header equal to the command.
  - Then uc_rd at the same addr → data[63:0]=0xDEADBEEF_CAFEF00D, upper bits 0.
  - resp_v asserts exactly 2 cycles after each accept with latency_p=0.
- Byte mask: fill block 0 with 0x11 bytes via a 64B wr; then 1B uc_wr addr=0x3 data=0xAB → 64B rd returns 0x11 everywhere except byte3=0xAB.
- Backpressure:
  - Hold yumi=0 for 10 cycles → resp_o stable and ready=0 during the stall.
  - A second cmd_v is not accepted until one cycle after yumi.
- Latency and reset:
  - latency_p=4: resp_v 6 cycles after accept.
  - Assert reset_n_i during e_wait → resp_v never asserts; ready=1 one cycle after release.
- With BP_MEM_RESPONDER_RANGE_CHECK_EN, els_p=1024:
  - Write to addr 0x1_0000 (= 1024*64) → err_o=1 and the SRAM is unchanged; a read at addr 0 still returns its prior value.
  - Without the macro, the same write aliases to index 0.

Source files
------------

// File: rtl/bp_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : bp_mem_responder_pkg                                       |
// | Brief   : CCE memory-message types, block geometry and byte-lane     |
// |           helpers shared by the memory responder and its SRAM.       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package bp_mem_responder_pkg;

   localparam int PADDR_WIDTH    = 40;
   localparam int BLOCK_WIDTH    = 512;
   localparam int BLOCK_BYTES    = BLOCK_WIDTH / 8;
   localparam int PAYLOAD_WIDTH  = 16;
   // log2 of the block byte count; also the largest legal size code
   localparam int LG_BLOCK_BYTES = $clog2(BLOCK_BYTES);
   localparam logic [2:0] MAX_SIZE_CODE = 3'(LG_BLOCK_BYTES);

   typedef enum logic [3:0] {
      e_cce_mem_rd    = 4'd0,
      e_cce_mem_wr    = 4'd1,
      e_cce_mem_uc_rd = 4'd2,
      e_cce_mem_uc_wr = 4'd3,
      e_cce_mem_pre   = 4'd4
   } bp_cce_mem_cmd_type_e;

   typedef enum logic [2:0] {
      e_mem_msg_size_1  = 3'd0,
      e_mem_msg_size_2  = 3'd1,
      e_mem_msg_size_4  = 3'd2,
      e_mem_msg_size_8  = 3'd3,
      e_mem_msg_size_16 = 3'd4,
      e_mem_msg_size_32 = 3'd5,
      e_mem_msg_size_64 = 3'd6
   } bp_mem_msg_size_e;

   typedef struct packed {
      bp_cce_mem_cmd_type_e     msg_type;
      bp_mem_msg_size_e         size;
      logic [PADDR_WIDTH-1:0]   addr;
      logic [PAYLOAD_WIDTH-1:0] payload;
   } bp_cce_mem_hdr_s;

   typedef struct packed {
      bp_cce_mem_hdr_s          header;
      logic [BLOCK_WIDTH-1:0]   data;
   } bp_cce_mem_msg_s;

   localparam int CCE_MEM_MSG_WIDTH = $bits(bp_cce_mem_msg_s);

   // Low 2^sz byte lanes set; sz must already be clamped to the block size
   function automatic logic [BLOCK_BYTES-1:0] size_byte_mask(input logic [2:0] sz);
      logic [BLOCK_BYTES-1:0] m;
      for (int i = 0; i < BLOCK_BYTES; i++) begin
         m[i] = (i < (1 << sz));
      end
      return m;
   endfunction

   // Byte offset rounded down to a 2^sz boundary
   function automatic logic [LG_BLOCK_BYTES-1:0] align_offset(
      input logic [LG_BLOCK_BYTES-1:0] off,
      input logic [2:0]                sz
   );
      logic [LG_BLOCK_BYTES-1:0] a;
      for (int i = 0; i < LG_BLOCK_BYTES; i++) begin
         a[i] = off[i] & (i >= int'(sz));
      end
      return a;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_mem_responder_sram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bp_mem_responder_sram                                      |
// | Brief   : Single-port synchronous SRAM model, byte-masked write,     |
// |           registered read data that holds when not accessed.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bp_mem_responder_sram #(
   parameter int ELS    = 1024,
   parameter int WIDTH  = 512,
   parameter int ADDR_W = $clog2(ELS)
) (
   input  logic               i_clk,
   input  logic               i_v,
   input  logic               i_w,
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic [WIDTH-1:0]   i_data,
   input  logic [WIDTH/8-1:0] i_wmask,
   output logic [WIDTH-1:0]   o_data
);

   logic [WIDTH-1:0] r_mem [ELS];
   logic [WIDTH-1:0] r_data;

   // Byte-masked write; contents are intentionally never reset
   always_ff @(posedge i_clk) begin
      if (i_v && i_w) begin
         for (int b = 0; b < WIDTH/8; b++) begin
            if (i_wmask[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_data[8*b +: 8];
            end
         end
      end
   end

   // Read data registered; held stable while the array is idle
   always_ff @(posedge i_clk) begin
      if (i_v && !i_w) begin
         r_data <= r_mem[i_addr];
      end
   end

   assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/bp_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bp_mem_responder                                           |
// | Brief   : CCE memory-message target endpoint backed by a local SRAM; |
// |           one command in flight, one response per command.          |
// | Options : BP_MEM_RESPONDER_RANGE_CHECK_EN adds sticky err_o and      |
// |           suppresses out-of-range accesses instead of wrapping.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module bp_mem_responder
   import bp_mem_responder_pkg::*;
#(
   parameter int ELS_P     = 1024,
   parameter int LATENCY_P = 0
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [CCE_MEM_MSG_WIDTH-1:0] mem_cmd_i,
   input  logic                         mem_cmd_v_i,
   output logic                         mem_cmd_ready_o,
   output logic [CCE_MEM_MSG_WIDTH-1:0] mem_resp_o,
   output logic                         mem_resp_v_o,
   input  logic                         mem_resp_yumi_i
`ifdef BP_MEM_RESPONDER_RANGE_CHECK_EN
  ,output logic                         err_o
`endif
);

   localparam int         c_LG_ELS   = $clog2(ELS_P);
   localparam logic [7:0] c_LAT_LAST = 8'(LATENCY_P - 1);

   typedef enum logic [1:0] {
      e_ready  = 2'd0,
      e_access = 2'd1,
      e_wait   = 2'd2,
      e_resp   = 2'd3
   } state_e;

   state_e                    r_state;
   logic [7:0]                r_cnt;
   logic                      r_ready;
   logic                      r_resp_v;
   bp_cce_mem_msg_s           r_cmd;

   logic                      w_is_rd;
   logic                      w_is_wr;
   logic                      w_oor;
   logic [2:0]                w_sz;
   logic [LG_BLOCK_BYTES-1:0] w_off;
   logic [BLOCK_BYTES-1:0]    w_bytes;
   logic [BLOCK_BYTES-1:0]    w_wmask;
   logic [BLOCK_WIDTH-1:0]    w_wdata;
   logic [BLOCK_WIDTH-1:0]    w_bitmask;
   logic [BLOCK_WIDTH-1:0]    w_sram_q;
   logic [BLOCK_WIDTH-1:0]    w_rd_data;
   logic                      w_sram_v;
   bp_cce_mem_msg_s           w_resp;

   assign w_is_rd = (r_cmd.header.msg_type == e_cce_mem_rd)
                 || (r_cmd.header.msg_type == e_cce_mem_uc_rd);
   assign w_is_wr = (r_cmd.header.msg_type == e_cce_mem_wr)
                 || (r_cmd.header.msg_type == e_cce_mem_uc_wr);

`ifdef BP_MEM_RESPONDER_RANGE_CHECK_EN
   logic r_err;

   assign w_oor = |r_cmd.header.addr[PADDR_WIDTH-1:LG_BLOCK_BYTES+c_LG_ELS];

   // Sticky out-of-range flag, raised when the offending command is accessed
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_err <= 1'b0;
      end else if (r_state == e_access && w_oor) begin
         r_err <= 1'b1;
      end
   end

   assign err_o = r_err;
`else
   // Upper address bits simply alias onto the array
   logic w_unused_addr;
   assign w_unused_addr = ^r_cmd.header.addr[PADDR_WIDTH-1:LG_BLOCK_BYTES+c_LG_ELS];
   assign w_oor         = 1'b0;
`endif

   // Oversized requests cover the whole block
   assign w_sz    = (r_cmd.header.size > MAX_SIZE_CODE) ? MAX_SIZE_CODE : r_cmd.header.size;
   assign w_off   = align_offset(r_cmd.header.addr[LG_BLOCK_BYTES-1:0], w_sz);
   assign w_bytes = size_byte_mask(w_sz);

   // Command bytes [0 +: 2^size] steered to the aligned offset
   assign w_wmask = w_bytes << w_off;
   assign w_wdata = r_cmd.data << {w_off, 3'b000};

   // Expand the byte-lane mask to bit granularity for read extraction
   always_comb begin
      w_bitmask = '0;
      for (int b = 0; b < BLOCK_BYTES; b++) begin
         w_bitmask[8*b +: 8] = {8{w_bytes[b]}};
      end
   end

   assign w_rd_data = (w_sram_q >> {w_off, 3'b000}) & w_bitmask;

   assign w_sram_v = (r_state == e_access) && (w_is_rd || w_is_wr) && !w_oor;

   bp_mem_responder_sram #(
      .ELS    (ELS_P),
      .WIDTH  (BLOCK_WIDTH),
      .ADDR_W (c_LG_ELS)
   ) u_sram (
      .i_clk   (clk_i),
      .i_v     (w_sram_v),
      .i_w     (w_is_wr),
      .i_addr  (r_cmd.header.addr[LG_BLOCK_BYTES +: c_LG_ELS]),
      .i_data  (w_wdata),
      .i_wmask (w_wmask),
      .o_data  (w_sram_q)
   );

   // Response is the command header verbatim; data only for in-range reads
   always_comb begin
      w_resp        = r_cmd;
      w_resp.data   = (w_is_rd && !w_oor) ? w_rd_data : '0;
   end

   assign mem_resp_o      = (r_state == e_resp) ? w_resp : '0;
   assign mem_resp_v_o    = r_resp_v;
   assign mem_cmd_ready_o = r_ready;

   // Serial command FSM: accept, access, optional wait, hold response
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state  <= e_ready;
         r_cnt    <= '0;
         r_ready  <= 1'b0;
         r_resp_v <= 1'b0;
         r_cmd    <= '0;
      end else begin
         case (r_state)
            e_ready: begin
               r_ready <= 1'b1;
               if (mem_cmd_v_i && r_ready) begin
                  r_cmd   <= mem_cmd_i;
                  r_ready <= 1'b0;
                  r_state <= e_access;
               end
            end
            e_access: begin
               r_cnt <= '0;
               if (LATENCY_P == 0) begin
                  r_resp_v <= 1'b1;
                  r_state  <= e_resp;
               end else begin
                  r_state  <= e_wait;
               end
            end
            e_wait: begin
               if (r_cnt == c_LAT_LAST) begin
                  r_resp_v <= 1'b1;
                  r_state  <= e_resp;
               end else begin
                  r_cnt    <= r_cnt + 8'd1;
               end
            end
            e_resp: begin
               if (mem_resp_yumi_i) begin
                  r_resp_v <= 1'b0;
                  r_ready  <= 1'b1;
                  r_state  <= e_ready;
               end
            end
            default: r_state <= e_ready;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bp_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bp_mem_responder                                        |
// | Brief   : Directed self-checking bench for bp_mem_responder with a   |
// |           zero-latency instance and a latency-4 instance.            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_bp_mem_responder;
   import bp_mem_responder_pkg::*;

   localparam int W = CCE_MEM_MSG_WIDTH;
   typedef bp_cce_mem_msg_s msg_t;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b1;
   msg_t         cmd;
   logic         cmd_v0 = 1'b0;
   logic         cmd_v4 = 1'b0;
   logic         yumi0  = 1'b0;
   logic         yumi4  = 1'b0;
   logic [W-1:0] resp0, resp4;
   logic         ready0, ready4, resp_v0, resp_v4;
`ifdef BP_MEM_RESPONDER_RANGE_CHECK_EN
   logic         err0, err4;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bp_mem_responder #(.ELS_P(1024), .LATENCY_P(0)) dut0 (
      .clk_i           (clk),
      .reset_n_i       (rst_n),
      .mem_cmd_i       (cmd),
      .mem_cmd_v_i     (cmd_v0),
      .mem_cmd_ready_o (ready0),
      .mem_resp_o      (resp0),
      .mem_resp_v_o    (resp_v0),
      .mem_resp_yumi_i (yumi0)
`ifdef BP_MEM_RESPONDER_RANGE_CHECK_EN
     ,.err_o           (err0)
`endif
   );

   bp_mem_responder #(.ELS_P(1024), .LATENCY_P(4)) dut4 (
      .clk_i           (clk),
      .reset_n_i       (rst_n),
      .mem_cmd_i       (cmd),
      .mem_cmd_v_i     (cmd_v4),
      .mem_cmd_ready_o (ready4),
      .mem_resp_o      (resp4),
      .mem_resp_v_o    (resp_v4),
      .mem_resp_yumi_i (yumi4)
`ifdef BP_MEM_RESPONDER_RANGE_CHECK_EN
     ,.err_o           (err4)
`endif
   );

   task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic msg_t mk(input bp_cce_mem_cmd_type_e t, input bp_mem_msg_size_e s,
                               input logic [PADDR_WIDTH-1:0] a, input logic [BLOCK_WIDTH-1:0] d);
      msg_t x;
      x.header.msg_type = t;
      x.header.size     = s;
      x.header.addr     = a;
      x.header.payload  = 16'h0A5C;
      x.data            = d;
      return x;
   endfunction

   function automatic msg_t resp_of(input msg_t m, input logic [BLOCK_WIDTH-1:0] d);
      msg_t x;
      x      = m;
      x.data = d;
      return x;
   endfunction

   function automatic logic rdy(input bit sel);
      return sel ? ready4 : ready0;
   endfunction

   function automatic logic rv(input bit sel);
      return sel ? resp_v4 : resp_v0;
   endfunction

   // Full transaction; lat = negedges from accept edge to first resp_v sample
   task automatic do_cmd(input bit sel, input msg_t m, output msg_t r, output int lat);
      int n;
      @(negedge clk);
      cmd = m;
      if (sel) cmd_v4 = 1'b1; else cmd_v0 = 1'b1;
      n = 0;
      while (!rdy(sel) && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmd_v0 = 1'b0;
      cmd_v4 = 1'b0;
      lat = 1;
      while (!rv(sel) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      r = sel ? msg_t'(resp4) : msg_t'(resp0);
      if (sel) yumi4 = 1'b1; else yumi0 = 1'b1;
      @(negedge clk);
      yumi0 = 1'b0;
      yumi4 = 1'b0;
   endtask

   initial begin
      msg_t                   m, m2, r;
      int                     lat, n;
      logic [BLOCK_WIDTH-1:0] blk;
      logic [W-1:0]           first;
      logic                   f_v, f_r, f_stable;
      logic [PADDR_WIDTH-1:0] a8;

`ifdef BP_MEM_RESPONDER_RANGE_CHECK_EN
      a8 = 40'h00_0000_0008;
`else
      a8 = 40'h00_8000_0008;
`endif
      cmd = '0;

      // Reset held for 5 cycles
      #2 rst_n = 1'b0;
      f_v = 1'b0;
      f_r = 1'b0;
      repeat (5) begin
         @(negedge clk);
         f_v |= resp_v0 | resp_v4;
         f_r |= ready0 | ready4;
      end
      check_eq("rst_resp_v", W'(f_v), W'(0));
      check_eq("rst_ready", W'(f_r), W'(0));
      check_eq("rst_resp_o", resp0, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rel_ready0", W'(ready0), W'(1));
      check_eq("rel_ready4", W'(ready4), W'(1));
      check_eq("rel_resp_v", W'(resp_v0), W'(0));
`ifdef BP_MEM_RESPONDER_RANGE_CHECK_EN
      check_eq("err_after_rst", W'(err0), W'(0));
`endif

      // Write then read 8 bytes
      m = mk(e_cce_mem_uc_wr, e_mem_msg_size_8, a8, BLOCK_WIDTH'(64'hDEADBEEF_CAFEF00D));
      do_cmd(1'b0, m, r, lat);
      check_eq("wr8_lat", W'(lat), W'(2));
      check_eq("wr8_resp", r, resp_of(m, '0));
      m = mk(e_cce_mem_uc_rd, e_mem_msg_size_8, a8, '0);
      do_cmd(1'b0, m, r, lat);
      check_eq("rd8_lat", W'(lat), W'(2));
      check_eq("rd8_resp", r, resp_of(m, BLOCK_WIDTH'(64'hDEADBEEF_CAFEF00D)));

      // Byte mask: fill block 0 with 0x11, patch byte 3
      blk = {BLOCK_BYTES{8'h11}};
      m = mk(e_cce_mem_wr, e_mem_msg_size_64, 40'h0, blk);
      do_cmd(1'b0, m, r, lat);
      check_eq("fill_resp", r, resp_of(m, '0));
      m = mk(e_cce_mem_uc_wr, e_mem_msg_size_1, 40'h3, BLOCK_WIDTH'(64'hFFFF_FFFF_FFFF_FFAB));
      do_cmd(1'b0, m, r, lat);
      check_eq("wr1_resp", r, resp_of(m, '0));
      blk[31:24] = 8'hAB;
      m = mk(e_cce_mem_rd, e_mem_msg_size_64, 40'h0, '0);
      do_cmd(1'b0, m, r, lat);
      check_eq("rd64_mask", r, resp_of(m, blk));

      // Alignment: 4B at 0x6 reads bytes 4..7, 2B at 0x3 reads bytes 2..3
      m = mk(e_cce_mem_rd, e_mem_msg_size_4, 40'h6, '0);
      do_cmd(1'b0, m, r, lat);
      check_eq("rd4_align", r, resp_of(m, BLOCK_WIDTH'(32'h1111_1111)));
      m = mk(e_cce_mem_uc_rd, e_mem_msg_size_2, 40'h3, '0);
      do_cmd(1'b0, m, r, lat);
      check_eq("rd2_align", r, resp_of(m, BLOCK_WIDTH'(16'hAB11)));

      // Other msg_type: data 0, no SRAM change; oversize read clamps to block
      m = mk(e_cce_mem_pre, e_mem_msg_size_64, 40'h0, {BLOCK_WIDTH{1'b1}});
      do_cmd(1'b0, m, r, lat);
      check_eq("pre_resp", r, resp_of(m, '0));
      m = mk(e_cce_mem_rd, bp_mem_msg_size_e'(3'd7), 40'h25, '0);
      do_cmd(1'b0, m, r, lat);
      check_eq("rd_clamp", r, resp_of(m, blk));

      // Backpressure with a second command waiting
      m  = mk(e_cce_mem_rd, e_mem_msg_size_8, 40'h0, '0);
      m2 = mk(e_cce_mem_uc_rd, e_mem_msg_size_1, 40'h3, '0);
      @(negedge clk);
      cmd    = m;
      cmd_v0 = 1'b1;
      n = 0;
      while (!ready0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmd = m2;
      n = 0;
      while (!resp_v0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      first = resp0;
      check_eq("bp_first", first, resp_of(m, BLOCK_WIDTH'(64'h1111_1111_AB11_1111)));
      f_stable = 1'b1;
      f_r      = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (resp0 !== first || !resp_v0) f_stable = 1'b0;
         f_r |= ready0;
      end
      check_eq("bp_stable", W'(f_stable), W'(1));
      check_eq("bp_ready_stall", W'(f_r), W'(0));
      yumi0 = 1'b1;
      @(negedge clk);
      yumi0 = 1'b0;
      check_eq("bp_ready_after_yumi", W'(ready0), W'(1));
      check_eq("bp_resp_v_after_yumi", W'(resp_v0), W'(0));
      @(negedge clk);
      cmd_v0 = 1'b0;
      check_eq("bp_second_accepted", W'(ready0), W'(0));
      lat = 1;
      while (!resp_v0 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_eq("bp_second_lat", W'(lat), W'(2));
      check_eq("bp_second_resp", resp0, resp_of(m2, BLOCK_WIDTH'(8'hAB)));
      yumi0 = 1'b1;
      @(negedge clk);
      yumi0 = 1'b0;

      // Address 1024*64: out of range when checked, aliases to index 0 otherwise
      m = mk(e_cce_mem_uc_wr, e_mem_msg_size_8, 40'h1_0000, BLOCK_WIDTH'(64'h0123_4567_89AB_CDEF));
      do_cmd(1'b0, m, r, lat);
      check_eq("hi_wr_resp", r, resp_of(m, '0));
      m = mk(e_cce_mem_uc_rd, e_mem_msg_size_8, 40'h0, '0);
      do_cmd(1'b0, m, r, lat);
`ifdef BP_MEM_RESPONDER_RANGE_CHECK_EN
      check_eq("oor_err", W'(err0), W'(1));
      check_eq("oor_unchanged", r, resp_of(m, BLOCK_WIDTH'(64'h1111_1111_AB11_1111)));
`else
      check_eq("alias_idx0", r, resp_of(m, BLOCK_WIDTH'(64'h0123_4567_89AB_CDEF)));
`endif

      // Latency 4 instance
      m = mk(e_cce_mem_uc_wr, e_mem_msg_size_8, 40'h40, BLOCK_WIDTH'(64'hA5A5_5A5A_0F0F_F0F0));
      do_cmd(1'b1, m, r, lat);
      check_eq("l4_wr_lat", W'(lat), W'(6));
      check_eq("l4_wr_resp", r, resp_of(m, '0));

      // Reset during wait: response dropped, write stays committed
      m = mk(e_cce_mem_wr, e_mem_msg_size_8, 40'h80, BLOCK_WIDTH'(64'hFEED_FACE_1234_5678));
      @(negedge clk);
      cmd    = m;
      cmd_v4 = 1'b1;
      n = 0;
      while (!ready4 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmd_v4 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      f_v = 1'b0;
      repeat (3) begin
         @(negedge clk);
         f_v |= resp_v4;
      end
      check_eq("l4_rst_ready", W'(ready4), W'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("l4_rel_ready", W'(ready4), W'(1));
      repeat (8) begin
         @(negedge clk);
         f_v |= resp_v4;
      end
      check_eq("l4_dropped_resp", W'(f_v), W'(0));
      m = mk(e_cce_mem_rd, e_mem_msg_size_8, 40'h80, '0);
      do_cmd(1'b1, m, r, lat);
      check_eq("l4_rd_lat", W'(lat), W'(6));
      check_eq("l4_rd_committed", r, resp_of(m, BLOCK_WIDTH'(64'hFEED_FACE_1234_5678)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
